seg7_scan_controller: RTL and testbench



---
 rtl/seg7_scan_controller.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 4-digit multiplexed seven-segment driver.
// A 16-bit hex value and four decimal-point enables are written through a
// ready/valid port into a pending buffer. The buffer is promoted to the
// displayed value only at frame boundaries, so a frame never shows a mix of
// old and new digits. Each digit slot lasts CLK_DIV cycles. The last cycle
// of every slot is dark, which gives blanking dead time between digits.
// AN and BCD are active-low. BCD = {dp, g, f, e, d, c, b, a}.
module seg7_scan_controller #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_en,
  output logic        wr_ready,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        frame_done
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  // Pending-buffer occupancy: EMPTY accepts writes, FULL waits for a frame boundary.
  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_e;

  buf_state_e    buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [15:0]   act_data_q, act_data_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    bcd_q, bcd_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    cur_nibble;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state logic: scan counters, write/commit handshake, output decode.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    an_d         = '1;
    bcd_d        = '1;
    frame_done_d = 1'b0;

    slot_end   = (cnt_q == CNT_LAST);
    frame_end  = slot_end && (idx_q == 2'd3);
    cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];

    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    frame_done_d = frame_end;

    // A write accepted on the boundary edge lands in pending only, since
    // commit is taken from the FULL state and pending was empty then.
    if (buf_q == BUF_EMPTY) begin
      if (wr_en) begin
        pend_data_d = wr_data;
        pend_dp_d   = wr_dp;
        buf_d       = BUF_FULL;
      end
    end else begin
      if (frame_end) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        buf_d      = BUF_EMPTY;
      end
    end

    // Outputs come from the pre-edge slot. The final cycle of a slot stays dark.
    if (!blank_en && !slot_end) begin
      an_d  = ~(4'b0001 << idx_q);
      bcd_d = {~act_dp_q[idx_q], seg7(cur_nibble)};
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q        <= BUF_EMPTY;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      an_q         <= '1;
      bcd_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = (buf_q == BUF_EMPTY);
  assign AN         = an_q;
  assign BCD        = bcd_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller with CLK_DIV=4 (16-cycle frame).
// The stimulus process drives one edge at a time and queues the expected
// post-edge outputs. The monitor pops one entry on each falling edge and
// compares it with the DUT.
module tb_seg7_scan_controller;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        blank_en;
  logic        wr_ready;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        frame_done;

  seg7_scan_controller #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .blank_en   (blank_en),
    .wr_ready   (wr_ready),
    .AN         (AN),
    .BCD        (BCD),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  bcd;
    logic        rdy;
    logic        fd;
    int unsigned k;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Bench-side view of what should be displayed and whether writes are open.
  int unsigned k = 0;
  logic [15:0] shown_val = 16'h0000;
  logic [3:0]  shown_dp  = 4'b0000;
  logic        exp_ready = 1'b1;

  // Hand table of active-low segment bytes with dp off.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_reset_exp();
    exp_t e;
    e.an = 4'hF; e.bcd = 8'hFF; e.rdy = 1'b1; e.fd = 1'b0; e.k = 0;
    exp_q.push_back(e);
  endtask

  // One edge after reset release: k counts edges. Edge k sees slot (k-1).
  task automatic tick(input logic we, input logic [15:0] d, input logic [3:0] dp, input logic blk);
    exp_t e;
    int unsigned p, slot_cyc, digit;
    logic [3:0] nib;
    wr_en = we; wr_data = d; wr_dp = dp; blank_en = blk;
    @(posedge clk);
    #1;
    k++;
    p        = k - 1;
    slot_cyc = p % DIV;
    digit    = (p / DIV) % 4;
    nib      = shown_val[digit*4 +: 4];
    if (blk || slot_cyc == DIV - 1) begin
      e.an  = 4'hF;
      e.bcd = 8'hFF;
    end else begin
      e.an  = ~(4'b0001 << digit);
      e.bcd = seg_tab[nib] & {~shown_dp[digit], 7'h7F};
    end
    e.rdy = exp_ready;
    e.fd  = (k % (4 * DIV) == 0);
    e.k   = k;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 16'h0000, 4'b0000, 1'b0);
  endtask

  // Monitor: one expected entry per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (AN !== e.an) begin
          n_fail++;
          $display("FAIL an k=%0d got %b want %b", e.k, AN, e.an);
        end
        n_cmp++;
        if (BCD !== e.bcd) begin
          n_fail++;
          $display("FAIL bcd k=%0d got %h want %h", e.k, BCD, e.bcd);
        end
        n_cmp++;
        if (wr_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL wr_ready k=%0d got %b want %b", e.k, wr_ready, e.rdy);
        end
        n_cmp++;
        if (frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL frame_done k=%0d got %b want %b", e.k, frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    int unsigned waited;
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0; blank_en = 1'b0;

    // Reset state.
    repeat (2) begin
      @(posedge clk); #1; push_reset_exp();
    end
    @(posedge clk); #1; reset = 1'b1; push_reset_exp();
    k = 0;

    // Frame 0: display 0000, frame_done after edge 16.
    idle(20);

    // Mid-frame write of 1A3F, dp on digit 1. Ready drops until boundary 32.
    exp_ready = 1'b0;
    tick(1'b1, 16'h1A3F, 4'b0010, 1'b0);          // k=21
    idle(2);                                       // k=22..23
    tick(1'b1, 16'hFFFF, 4'b1111, 1'b0);          // k=24, ignored
    idle(7);                                       // k=25..31
    shown_val = 16'h1A3F; shown_dp = 4'b0010; exp_ready = 1'b1;
    idle(1);                                       // k=32, commit edge
    idle(31);                                      // k=33..63

    // Write on the boundary edge itself: commit waits one full frame.
    exp_ready = 1'b0;
    tick(1'b1, 16'h4B7E, 4'b1000, 1'b0);          // k=64
    idle(15);                                      // k=65..79
    shown_val = 16'h4B7E; shown_dp = 4'b1000; exp_ready = 1'b1;
    idle(1);                                       // k=80
    idle(19);                                      // k=81..99

    // Blanking for 10 cycles. Scan timing continues underneath.
    repeat (10) tick(1'b0, 16'h0000, 4'b0000, 1'b1); // k=100..109
    idle(5);                                       // k=110..114

    // Pending write, then asynchronous reset between edges.
    exp_ready = 1'b0;
    tick(1'b1, 16'h2222, 4'b1111, 1'b0);          // k=115
    idle(1);                                       // k=116
    wr_en = 1'b0; blank_en = 1'b0;
    @(posedge clk); #1; reset = 1'b0; push_reset_exp();
    @(posedge clk); #1; push_reset_exp();
    @(posedge clk); #1; reset = 1'b1; push_reset_exp();
    k = 0; shown_val = 16'h0000; shown_dp = 4'b0000; exp_ready = 1'b1;
    idle(24);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain left %0d entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
